fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RISC-V pipeline. It owns the program counter and drives the word address into the instruction memory, which has a combinational read. It captures the returned instruction into the IF/ID pipeline register for the decode stage. It also handles stall, taken-branch/jump redirect from execute (with flush), and keeps a retired-fetch counter for debug.

---
 rtl/fetch_stage.sv | 82 ++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory address and registers the returned word into the IF/ID register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
   parameter int          IMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_f,
   input  logic        pcsrc_e,
   input  logic [31:0] pc_target_e,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus4_d,
   output logic        valid_d,
   output logic        misalign_err,
   output logic        oor_err,
   output logic [31:0] fetch_count
);

   // One extra bit so a memory of 2^30 words still yields a meaningful limit.
   localparam logic [32:0] OOR_LIMIT = 33'(IMEM_WORDS) << 2;

   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_pcD;
   logic [31:0] r_pcPlus4D;
   logic        r_valid;
   logic        r_misalign;
   logic [31:0] r_fetchCount;

   logic [31:0] w_pcPlus4;
   logic [31:0] w_targetAligned;
   logic        w_outOfRange;

   assign w_pcPlus4       = r_pc + 32'd4;
   assign w_targetAligned = {pc_target_e[31:2], 2'b00};
   assign w_outOfRange    = ({1'b0, r_pc} >= OOR_LIMIT);

   // Redirect outranks stall so a taken branch is never lost behind a hazard.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc         <= RESET_PC;
         r_instr      <= NOP_INSTR;
         r_pcD        <= 32'd0;
         r_pcPlus4D   <= 32'd0;
         r_valid      <= 1'b0;
         r_misalign   <= 1'b0;
         r_fetchCount <= 32'd0;
      end else if (pcsrc_e) begin
         r_pc         <= w_targetAligned;
         r_instr      <= NOP_INSTR;
         r_pcD        <= 32'd0;
         r_pcPlus4D   <= 32'd0;
         r_valid      <= 1'b0;
         r_misalign   <= (pc_target_e[1:0] != 2'b00);
      end else if (stall_f) begin
         r_misalign   <= 1'b0;
      end else begin
         r_pc         <= w_pcPlus4;
         r_instr      <= imem_rdata;
         r_pcD        <= r_pc;
         r_pcPlus4D   <= w_pcPlus4;
         r_valid      <= 1'b1;
         r_misalign   <= 1'b0;
         r_fetchCount <= r_fetchCount + 32'd1;
      end
   end

   assign imem_addr    = r_pc;
   assign oor_err      = w_outOfRange;
   assign instr_d      = r_instr;
   assign pc_d         = r_pcD;
   assign pc_plus4_d   = r_pcPlus4D;
   assign valid_d      = r_valid;
   assign misalign_err = r_misalign;
   assign fetch_count  = r_fetchCount;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: reset, sequential fetch, stall,
// redirect/flush, misaligned target, async reset and PC boundary behaviour.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall_f;
   logic        pcsrc_e;
   logic [31:0] pc_target_e;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4_d;
   logic        valid_d;
   logic        misalign_err;
   logic        oor_err;
   logic [31:0] fetch_count;

   logic [31:0] imem_addr2;
   logic [31:0] imem_rdata2;
   logic [31:0] instr_d2;
   logic [31:0] pc_d2;
   logic [31:0] pc_plus4_d2;
   logic        valid_d2;
   logic        misalign_err2;
   logic        oor_err2;
   logic [31:0] fetch_count2;

   logic [31:0] mem [0:1023];
   int          testsRun;
   int          testsFailed;

   fetch_stage dut (
      .clk(clk), .rst(rst), .stall_f(stall_f), .pcsrc_e(pcsrc_e),
      .pc_target_e(pc_target_e), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
      .misalign_err(misalign_err), .oor_err(oor_err), .fetch_count(fetch_count)
   );

   // Second instance starts just below the memory limit to exercise oor_err.
   fetch_stage #(.RESET_PC(32'h0000_0FFC)) dutHigh (
      .clk(clk), .rst(rst), .stall_f(1'b0), .pcsrc_e(1'b0),
      .pc_target_e(32'd0), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .instr_d(instr_d2), .pc_d(pc_d2), .pc_plus4_d(pc_plus4_d2), .valid_d(valid_d2),
      .misalign_err(misalign_err2), .oor_err(oor_err2), .fetch_count(fetch_count2)
   );

   assign imem_rdata  = mem[imem_addr[11:2]];
   assign imem_rdata2 = mem[imem_addr2[11:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %08h, expected %08h", tag, actual, expected);
      end
   endtask

   // Drive inputs for one cycle, let the edge happen, then sample on the falling edge.
   task automatic applyStimulus(input logic stall, input logic pcsrc, input logic [31:0] target);
      stall_f     = stall;
      pcsrc_e     = pcsrc;
      pc_target_e = target;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
      mem[0]    = 32'hFFC4A303;
      mem[1]    = 32'h00832383;
      mem[2]    = 32'h0064A423;
      mem[3]    = 32'h00B50533;
      mem[6]    = 32'h0020A023;
      mem[8]    = 32'h00108113;
      mem[16]   = 32'h00A00093;
      mem[1023] = 32'hDEADBEEF;

      stall_f = 1'b0; pcsrc_e = 1'b0; pc_target_e = 32'd0;
      rst = 1'b1;
      #2 rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_addr",     imem_addr,    32'h0);
      checkOutput("rst_instr",    instr_d,      32'h13);
      checkOutput("rst_pcd",      pc_d,         32'h0);
      checkOutput("rst_pc4d",     pc_plus4_d,   32'h0);
      checkOutput("rst_valid",    32'(valid_d), 32'h0);
      checkOutput("rst_misalign", 32'(misalign_err), 32'h0);
      checkOutput("rst_count",    fetch_count,  32'h0);
      checkOutput("rst_oor",      32'(oor_err), 32'h0);
      checkOutput("hi_rst_addr",  imem_addr2,   32'hFFC);
      checkOutput("hi_rst_oor",   32'(oor_err2), 32'h0);
      rst = 1'b1;

      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("f1_instr", instr_d, 32'hFFC4A303);
      checkOutput("f1_pcd",   pc_d,    32'h0);
      checkOutput("f1_pc4d",  pc_plus4_d, 32'h4);
      checkOutput("f1_valid", 32'(valid_d), 32'h1);
      checkOutput("hi_addr",  imem_addr2, 32'h1000);
      checkOutput("hi_oor",   32'(oor_err2), 32'h1);
      checkOutput("hi_instr", instr_d2, 32'hDEADBEEF);
      checkOutput("hi_pcd",   pc_d2, 32'hFFC);

      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("f2_instr", instr_d, 32'h00832383);
      checkOutput("f2_pcd",   pc_d,    32'h4);
      checkOutput("f2_addr",  imem_addr, 32'h8);

      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 1'b0, 32'd0);
         checkOutput("stall_addr",  imem_addr,   32'h8);
         checkOutput("stall_instr", instr_d,     32'h00832383);
         checkOutput("stall_pcd",   pc_d,        32'h4);
         checkOutput("stall_count", fetch_count, 32'h2);
      end

      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("f3_instr", instr_d,     32'h0064A423);
      checkOutput("f3_pcd",   pc_d,        32'h8);
      checkOutput("f3_valid", 32'(valid_d), 32'h1);
      checkOutput("f3_count", fetch_count, 32'h3);
      checkOutput("f3_addr",  imem_addr,   32'hC);

      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("f4_instr", instr_d,   32'h00B50533);
      checkOutput("f4_addr",  imem_addr, 32'h10);

      applyStimulus(1'b0, 1'b1, 32'h40);
      checkOutput("redir_addr",     imem_addr,   32'h40);
      checkOutput("redir_instr",    instr_d,     32'h13);
      checkOutput("redir_valid",    32'(valid_d), 32'h0);
      checkOutput("redir_pcd",      pc_d,        32'h0);
      checkOutput("redir_misalign", 32'(misalign_err), 32'h0);
      checkOutput("redir_count",    fetch_count, 32'h4);

      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("tgt_pcd",   pc_d,        32'h40);
      checkOutput("tgt_instr", instr_d,     32'h00A00093);
      checkOutput("tgt_valid", 32'(valid_d), 32'h1);
      checkOutput("tgt_count", fetch_count, 32'h5);

      applyStimulus(1'b1, 1'b1, 32'h22);
      checkOutput("mis_addr",  imem_addr,   32'h20);
      checkOutput("mis_valid", 32'(valid_d), 32'h0);
      checkOutput("mis_flag",  32'(misalign_err), 32'h1);

      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("mis_clear", 32'(misalign_err), 32'h0);
      checkOutput("mis_pcd",   pc_d,    32'h20);
      checkOutput("mis_instr", instr_d, 32'h00108113);

      applyStimulus(1'b0, 1'b1, 32'h18);
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("pre_addr",  imem_addr,   32'h1C);
      checkOutput("pre_valid", 32'(valid_d), 32'h1);
      checkOutput("pre_instr", instr_d,     32'h0020A023);

      #2 rst = 1'b0;
      #1;
      checkOutput("arst_addr",  imem_addr,   32'h0);
      checkOutput("arst_valid", 32'(valid_d), 32'h0);
      checkOutput("arst_instr", instr_d,     32'h13);
      checkOutput("arst_pcd",   pc_d,        32'h0);
      checkOutput("arst_count", fetch_count, 32'h0);

      // Redirect is armed while reset holds, so the first live edge jumps to the top.
      pcsrc_e = 1'b1; pc_target_e = 32'hFFFF_FFFC;
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_addr", imem_addr, 32'h0);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
      checkOutput("top_addr", imem_addr, 32'hFFFF_FFFC);
      checkOutput("top_oor",  32'(oor_err), 32'h1);

      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("wrap_addr",  imem_addr,  32'h0);
      checkOutput("wrap_oor",   32'(oor_err), 32'h0);
      checkOutput("wrap_instr", instr_d,    32'hDEADBEEF);
      checkOutput("wrap_pcd",   pc_d,       32'hFFFF_FFFC);
      checkOutput("wrap_pc4d",  pc_plus4_d, 32'h0);
      checkOutput("wrap_count", fetch_count, 32'h1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
